// File: rtl/cmos_deadtime_ctrl.sv
// cmos_deadtime_ctrl: break-before-make gate sequencer for a pmos/nmos output stage
module cmos_deadtime_ctrl #(
  parameter int DT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cmd,
  input  logic [DT_W-1:0]  dead_cycles,
  output logic             pmos_gate,
  output logic             nmos_gate,
  output logic             drive_on,
  output logic             busy,
  output logic [CNT_W-1:0] trans_cnt
);
  localparam logic [1:0] OFF = 2'd0, DEAD = 2'd1, HIGH = 2'd2, LOW = 2'd3;
  logic [1:0] state;
  logic target;
  logic [DT_W-1:0] dcnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OFF;
      dcnt <= '0;
      target <= 1'b0;
      trans_cnt <= '0;
    end else begin
      case (state)
        OFF: if (en) begin
          state <= DEAD;
          dcnt <= dead_cycles;
          target <= cmd;
        end
        DEAD: if (!en) state <= OFF;
        else if (dcnt != '0) begin
          dcnt <= dcnt - 1'b1;
          if (target != cmd) target <= cmd;
        end else begin
          state <= cmd ? HIGH : LOW;
          if (trans_cnt != '1) trans_cnt <= trans_cnt + 1'b1;
        end
        HIGH: if (!en) state <= OFF;
        else if (!cmd) begin
          state <= DEAD;
          dcnt <= dead_cycles;
        end
        default: if (!en) state <= OFF;
        else if (cmd) begin
          state <= DEAD;
          dcnt <= dead_cycles;
        end
      endcase
    end
  end
  assign pmos_gate = state != HIGH;
  assign nmos_gate = state == LOW;
  assign drive_on = state == HIGH || state == LOW;
  assign busy = state == DEAD;
endmodule
